// File: rtl/matdet_pkg.sv
// rtl/matdet_pkg.sv - shared FSM encodings and index helpers for the sequential determinant block
package matdet_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PROD = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int unsigned fact(input int unsigned n);
    int unsigned f;
    f = 1;
    for (int unsigned i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Row-major element index into the flattened matrix bus, (0,0) at the LSBs.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matdet_perm_gen.sv
// rtl/matdet_perm_gen.sv - iterative Heap permutation generator with parity tracking
module matdet_perm_gen #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          step,
  output logic [N*PW-1:0] perm,
  output logic          sign,
  output logic          last
);

  logic [PW-1:0] perm_q [N];
  logic [PW-1:0] perm_d [N];
  logic [PW-1:0] c_q    [N];
  logic [PW-1:0] c_d    [N];
  logic          sign_q;
  logic          sign_d;
  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] swp;
  logic [PW-1:0] tmp;

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N - 1; i >= 1; i--) begin
      if (c_q[i] < PW'(i)) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
  end

  always_comb begin
    perm_d = perm_q;
    c_d    = c_q;
    sign_d = sign_q;
    swp    = sel[0] ? c_q[sel] : '0;
    tmp    = perm_q[sel];
    if (init) begin
      for (int j = 0; j < N; j++) begin
        perm_d[j] = PW'(j);
        c_d[j]    = '0;
      end
      sign_d = 1'b0;
    end else if (step && found) begin
      perm_d[sel] = perm_q[swp];
      perm_d[swp] = tmp;
      c_d[sel]    = c_q[sel] + 1'b1;
      for (int j = 0; j < N; j++) begin
        if (PW'(j) < sel) c_d[j] = '0;
      end
      sign_d = ~sign_q;
    end
  end

  always_comb begin
    perm = '0;
    for (int j = 0; j < N; j++) perm[j*PW +: PW] = perm_q[j];
  end

  assign sign = sign_q;
  assign last = ~found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        perm_q[j] <= PW'(j);
        c_q[j]    <= '0;
      end
      sign_q <= 1'b0;
    end else begin
      perm_q <= perm_d;
      c_q    <= c_d;
      sign_q <= sign_d;
    end
  end

endmodule

// File: rtl/matdet_seq.sv
// rtl/matdet_seq.sv - sequential Leibniz determinant, one multiplier and one adder, mod 2^DATA_WIDTH
// Optional cycle counter output enabled by MATDET_CYCLES_EN.
module matdet_seq
  import matdet_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int N           = 4,
  parameter int MATRIX_SIZE = N * N
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             det,
  output logic                              out_valid,
  input  logic                              out_ready
`ifdef MATDET_CYCLES_EN
  ,
  output logic [31:0]                       cycles
`endif
);

  localparam int PW = $clog2(N);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_lat_q [N][N];
  logic [DATA_WIDTH-1:0] a_lat_d [N][N];
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH-1:0] det_q, det_d;
  logic [PW-1:0]         k_q, k_d;
  logic                  out_valid_q, out_valid_d;
`ifdef MATDET_CYCLES_EN
  logic [31:0]           cycles_q, cycles_d;
`endif

  logic                  pg_init;
  logic                  pg_step;
  logic [N*PW-1:0]       pg_perm;
  logic                  pg_sign;
  logic                  pg_last;
  logic [PW-1:0]         perm_k;
  logic [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH-1:0] acc_new;

  matdet_perm_gen #(.N(N), .PW(PW)) u_perm_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (pg_init),
    .step  (pg_step),
    .perm  (pg_perm),
    .sign  (pg_sign),
    .last  (pg_last)
  );

  assign perm_k  = pg_perm[int'(k_q)*PW +: PW];
  assign elem    = a_lat_q[k_q][perm_k];
  assign acc_new = pg_sign ? (acc_q - prod_q) : (acc_q + prod_q);

  always_comb begin
    state_d     = state_q;
    a_lat_d     = a_lat_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    det_d       = det_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    pg_init     = 1'b0;
    pg_step     = 1'b0;
`ifdef MATDET_CYCLES_EN
    cycles_d    = cycles_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              a_lat_d[r][c] = a[elem_idx(r, c, N)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          pg_init = 1'b1;
          acc_d   = '0;
          prod_d  = DATA_WIDTH'(1);
          k_d     = '0;
          state_d = ST_PROD;
`ifdef MATDET_CYCLES_EN
          cycles_d = '0;
`endif
        end
      end
      ST_PROD: begin
        prod_d = prod_q * elem;
        if (k_q == PW'(N - 1)) begin
          state_d = ST_ACC;
        end else begin
          k_d = k_q + 1'b1;
        end
`ifdef MATDET_CYCLES_EN
        cycles_d = cycles_q + 32'd1;
`endif
      end
      ST_ACC: begin
        acc_d   = acc_new;
        pg_step = 1'b1;
        if (pg_last) begin
          det_d       = acc_new;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          prod_d  = DATA_WIDTH'(1);
          k_d     = '0;
          state_d = ST_PROD;
        end
`ifdef MATDET_CYCLES_EN
        cycles_d = cycles_q + 32'd1;
`endif
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) a_lat_q[r][c] <= '0;
      end
      acc_q       <= '0;
      prod_q      <= '0;
      det_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MATDET_CYCLES_EN
      cycles_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_lat_q     <= a_lat_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      det_q       <= det_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
`ifdef MATDET_CYCLES_EN
      cycles_q    <= cycles_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign det       = det_q;
  assign out_valid = out_valid_q;
`ifdef MATDET_CYCLES_EN
  assign cycles    = cycles_q;
`endif

endmodule

// File: tb/tb_matdet_seq.sv
// tb/tb_matdet_seq.sv - directed bench for matdet_seq at N=2,3,4; cycle checks when MATDET_CYCLES_EN is defined
module tb_matdet_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  int          n_sel;
  logic [7:0]  m [6][6];
  int          n_chk;
  int          n_fail;

  logic [31:0]  a2;
  logic [71:0]  a3;
  logic [127:0] a4;
  logic ir2, ir3, ir4, ov2, ov3, ov4;
  logic [7:0] det2, det3, det4;
  logic ir, ov;
  logic [7:0] dt;
`ifdef MATDET_CYCLES_EN
  logic [31:0] cy2, cy3, cy4, cyc;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a2 = '0;
    a3 = '0;
    a4 = '0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) a2[(r*2+c)*8 +: 8] = m[r][c];
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) a3[(r*3+c)*8 +: 8] = m[r][c];
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a4[(r*4+c)*8 +: 8] = m[r][c];
  end

  always_comb begin
    ir = ir4;
    ov = ov4;
    dt = det4;
`ifdef MATDET_CYCLES_EN
    cyc = cy4;
`endif
    if (n_sel == 2) begin
      ir = ir2; ov = ov2; dt = det2;
`ifdef MATDET_CYCLES_EN
      cyc = cy2;
`endif
    end else if (n_sel == 3) begin
      ir = ir3; ov = ov3; dt = det3;
`ifdef MATDET_CYCLES_EN
      cyc = cy3;
`endif
    end
  end

  matdet_seq #(.DATA_WIDTH(8), .N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .in_valid(in_valid && n_sel == 2), .in_ready(ir2),
    .det(det2), .out_valid(ov2), .out_ready(out_ready && n_sel == 2)
`ifdef MATDET_CYCLES_EN
    , .cycles(cy2)
`endif
  );

  matdet_seq #(.DATA_WIDTH(8), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .in_valid(in_valid && n_sel == 3), .in_ready(ir3),
    .det(det3), .out_valid(ov3), .out_ready(out_ready && n_sel == 3)
`ifdef MATDET_CYCLES_EN
    , .cycles(cy3)
`endif
  );

  matdet_seq #(.DATA_WIDTH(8), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .in_valid(in_valid && n_sel == 4), .in_ready(ir4),
    .det(det4), .out_valid(ov4), .out_ready(out_ready && n_sel == 4)
`ifdef MATDET_CYCLES_EN
    , .cycles(cy4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int n);
    case (n)
      2:       return 6;
      3:       return 24;
      default: return 120;
    endcase
  endfunction

  function automatic logic [7:0] det3_ref();
    int d;
    d = int'(m[0][0]) * (int'(m[1][1]) * int'(m[2][2]) - int'(m[1][2]) * int'(m[2][1]))
      - int'(m[0][1]) * (int'(m[1][0]) * int'(m[2][2]) - int'(m[1][2]) * int'(m[2][0]))
      + int'(m[0][2]) * (int'(m[1][0]) * int'(m[2][1]) - int'(m[1][1]) * int'(m[2][0]));
    return d[7:0];
  endfunction

  task automatic clr_m();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) m[r][c] = 8'h00;
  endtask

  // Call at #1 after a rising edge with the selected instance idle.
  task automatic run(input string tag, input int n, input logic [7:0] exp,
                     input int hold, input bit intrude);
    int cnt;
    n_sel    = n;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, {31'd0, ir}, 32'd0);
    cnt = 0;
    while (ov !== 1'b1 && cnt < 2000) begin
      if (intrude && cnt == 3) begin
        check({tag, "_ready_in_prod"}, {31'd0, ir}, 32'd0);
        m[0][0]  = 8'h55;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, cnt, lat(n));
    check({tag, "_det"}, {24'd0, dt}, {24'd0, exp});
`ifdef MATDET_CYCLES_EN
    check({tag, "_cycles"}, cyc, lat(n));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, ov}, 32'd1);
      check({tag, "_hold_det"}, {24'd0, dt}, {24'd0, exp});
    end
`ifdef MATDET_CYCLES_EN
    if (hold > 0) check({tag, "_cycles_frozen"}, cyc, lat(n));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, ov}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, ir}, 32'd1);
    check({tag, "_det_kept"}, {24'd0, dt}, {24'd0, exp});
  endtask

  task automatic load_diag234();
    clr_m();
    m[0][0] = 8'd2; m[1][1] = 8'd3; m[2][2] = 8'd4;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_sel     = 3;
    clr_m();
    repeat (3) @(posedge clk);
    #1;
    for (int n = 2; n <= 4; n++) begin
      n_sel = n;
      #1;
      check("rst_out_valid", {31'd0, ov}, 32'd0);
      check("rst_det", {24'd0, dt}, 32'd0);
      check("rst_in_ready", {31'd0, ir}, 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    clr_m();
    m[0][0] = 8'd1; m[0][1] = 8'd2; m[1][0] = 8'd3; m[1][1] = 8'd4;
    run("n2_basic", 2, 8'hFE, 3, 1'b0);

    load_diag234();
    run("n3_diag", 3, 8'h18, 0, 1'b1);

    load_diag234();
    n_sel    = 3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", {31'd0, ov}, 32'd0);
    check("abort_det", {24'd0, dt}, 32'd0);
    check("abort_in_ready", {31'd0, ir}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready_rel", {31'd0, ir}, 32'd1);
    @(posedge clk); #1;
    run("n3_after_reset", 3, 8'h18, 0, 1'b0);

    clr_m();
    for (int i = 0; i < 4; i++) m[i][i] = 8'd1;
    run("n4_identity", 4, 8'h01, 0, 1'b0);

    clr_m();
    for (int c = 0; c < 4; c++) begin
      m[0][c] = 8'(c + 1);
      m[1][c] = 8'(c + 5);
      m[2][c] = 8'(c + 5);
      m[3][c] = 8'(3 * c + 9);
    end
    run("n4_equal_rows", 4, 8'h00, 0, 1'b0);

    clr_m();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m[r][c] = 8'hFF;
    run("n3_all_ff", 3, 8'h00, 0, 1'b0);

    clr_m();
    m[0][0] = 8'd16; m[1][1] = 8'd16; m[2][2] = 8'd1;
    run("n3_wrap", 3, 8'h00, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      clr_m();
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m[r][c] = 8'($urandom_range(0, 255));
      run("n3_random", 3, det3_ref(), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
